// File: rtl/wishbone_manager_if.sv
// wishbone_manager_if: request-unit and Wishbone classic signals seen by the manager
interface wishbone_manager_if #(
   parameter int ADR_WIDTH = 32,
   parameter int DAT_WIDTH = 32
);
   logic                   read_i;
   logic                   write_i;
   logic [ADR_WIDTH-1:0]   adr_i;
   logic [DAT_WIDTH-1:0]   cpu_dat_i;
   logic [DAT_WIDTH/8-1:0] sel_i;
   logic [DAT_WIDTH-1:0]   cpu_dat_o;
   logic                   busy_o;
   logic                   err_o;
   logic [ADR_WIDTH-1:0]   ADR_O;
   logic [DAT_WIDTH-1:0]   DAT_O;
   logic [DAT_WIDTH/8-1:0] SEL_O;
   logic                   WE_O;
   logic                   STB_O;
   logic                   CYC_O;
   logic [DAT_WIDTH-1:0]   DAT_I;
   logic                   ACK_I;
   modport master (
      input  read_i, write_i, adr_i, cpu_dat_i, sel_i, DAT_I, ACK_I,
      output cpu_dat_o, busy_o, err_o, ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O
   );
   modport slave (
      output read_i, write_i, adr_i, cpu_dat_i, sel_i, DAT_I, ACK_I,
      input  cpu_dat_o, busy_o, err_o, ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O
   );
endinterface

// File: rtl/wishbone_manager.sv
// wishbone_manager: turns level-held CPU requests into single Wishbone classic cycles with ACK timeout
module wishbone_manager #(
   parameter int ADR_WIDTH      = 32,
   parameter int DAT_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic               clk,
   input logic               rst,
   wishbone_manager_if.master bus
);
   localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] MAX = '1;
   typedef enum logic {IDLE, BUS} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic start, fin, abort;
   always_comb begin
      state_n = state;
      start   = 1'b0;
      fin     = 1'b0;
      abort   = 1'b0;
      if (state == IDLE) begin
         if (bus.read_i | bus.write_i) begin
            start   = 1'b1;
            state_n = BUS;
         end
      end else if (bus.ACK_I) begin
         fin     = 1'b1;
         state_n = IDLE;
      end else if (TIMEOUT_CYCLES != 0 && cnt == LAST) begin
         abort   = 1'b1;
         state_n = IDLE;
      end
   end
   // every output is a flop; start/fin/abort only steer their next values
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         cnt           <= '0;
         bus.cpu_dat_o <= '0;
         bus.busy_o    <= 1'b0;
         bus.err_o     <= 1'b0;
         bus.ADR_O     <= '0;
         bus.DAT_O     <= '0;
         bus.SEL_O     <= '0;
         bus.WE_O      <= 1'b0;
         bus.STB_O     <= 1'b0;
         bus.CYC_O     <= 1'b0;
      end else begin
         state     <= state_n;
         bus.err_o <= abort;
         if (start) begin
            bus.ADR_O  <= bus.adr_i;
            bus.DAT_O  <= bus.cpu_dat_i;
            bus.SEL_O  <= bus.sel_i;
            bus.WE_O   <= bus.write_i;
            bus.CYC_O  <= 1'b1;
            bus.STB_O  <= 1'b1;
            bus.busy_o <= 1'b1;
            cnt        <= '0;
         end
         if (state == BUS && !bus.ACK_I && cnt != MAX) cnt <= cnt + 1'b1;
         if (fin && !bus.WE_O) bus.cpu_dat_o <= bus.DAT_I;
         if (fin || abort) begin
            bus.CYC_O  <= 1'b0;
            bus.STB_O  <= 1'b0;
            bus.busy_o <= 1'b0;
            bus.WE_O   <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_wishbone_manager.sv
// tb_wishbone_manager: directed scenarios against wishbone_manager with TIMEOUT_CYCLES=4
module tb_wishbone_manager;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int checks = 0;
   int failures = 0;
   wishbone_manager_if #(.ADR_WIDTH(32), .DAT_WIDTH(32)) bus ();
   wishbone_manager #(.ADR_WIDTH(32), .DAT_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      checks++;
      if ({bus.cpu_dat_o, bus.busy_o, bus.err_o, bus.ADR_O, bus.DAT_O, bus.SEL_O, bus.WE_O, bus.STB_O, bus.CYC_O} !== '0) begin
         failures++; $display("FAIL reset_outputs cyc=%b busy=%b dat=%h adr=%h required all zero", bus.CYC_O, bus.busy_o, bus.cpu_dat_o, bus.ADR_O);
      end
      #3 rst = 1'b1;
      tick();
      checks++;
      if (bus.CYC_O !== 1'b0) begin failures++; $display("FAIL reset_idle cyc=%b required 0", bus.CYC_O); end
   endtask

   task automatic test_read();
      bus.read_i = 1'b1; bus.adr_i = 32'h10;
      tick();
      bus.read_i = 1'b0;
      checks++;
      if ({bus.CYC_O, bus.STB_O, bus.busy_o, bus.WE_O} !== 4'b1110) begin failures++; $display("FAIL read_start cyc/stb/busy/we=%b required 1110", {bus.CYC_O, bus.STB_O, bus.busy_o, bus.WE_O}); end
      checks++;
      if (bus.ADR_O !== 32'h10) begin failures++; $display("FAIL read_adr got=%h required=00000010", bus.ADR_O); end
      tick();
      checks++;
      if ({bus.CYC_O, bus.STB_O} !== 2'b11) begin failures++; $display("FAIL read_second_cycle cyc/stb=%b required 11", {bus.CYC_O, bus.STB_O}); end
      bus.ACK_I = 1'b1; bus.DAT_I = 32'hCAFEF00D;
      tick();
      bus.ACK_I = 1'b0;
      checks++;
      if ({bus.CYC_O, bus.STB_O, bus.busy_o, bus.err_o} !== 4'b0000) begin failures++; $display("FAIL read_end cyc/stb/busy/err=%b required 0000", {bus.CYC_O, bus.STB_O, bus.busy_o, bus.err_o}); end
      checks++;
      if (bus.cpu_dat_o !== 32'hCAFEF00D) begin failures++; $display("FAIL read_data got=%h required=cafef00d", bus.cpu_dat_o); end
   endtask

   task automatic test_write();
      bus.write_i = 1'b1; bus.adr_i = 32'h04; bus.cpu_dat_i = 32'h12345678; bus.sel_i = 4'hF;
      tick();
      bus.write_i = 1'b0;
      checks++;
      if ({bus.CYC_O, bus.WE_O, bus.DAT_O, bus.SEL_O, bus.ADR_O} !== {2'b11, 32'h12345678, 4'hF, 32'h04}) begin
         failures++; $display("FAIL write_start cyc=%b we=%b dat=%h sel=%h adr=%h required 1 1 12345678 f 00000004", bus.CYC_O, bus.WE_O, bus.DAT_O, bus.SEL_O, bus.ADR_O);
      end
      bus.ACK_I = 1'b1; bus.DAT_I = 32'hDEADBEEF;
      tick();
      bus.ACK_I = 1'b0;
      checks++;
      if ({bus.CYC_O, bus.busy_o, bus.WE_O} !== 3'b000) begin failures++; $display("FAIL write_end cyc/busy/we=%b required 000", {bus.CYC_O, bus.busy_o, bus.WE_O}); end
      checks++;
      if (bus.cpu_dat_o !== 32'hCAFEF00D) begin failures++; $display("FAIL write_keeps_rdata got=%h required=cafef00d", bus.cpu_dat_o); end
   endtask

   task automatic test_sel_zero();
      bus.write_i = 1'b1; bus.adr_i = 32'h08; bus.cpu_dat_i = 32'h0; bus.sel_i = 4'h0;
      tick();
      bus.write_i = 1'b0;
      checks++;
      if ({bus.CYC_O, bus.STB_O, bus.SEL_O} !== 6'b110000) begin failures++; $display("FAIL sel_zero cyc/stb/sel=%b required 110000", {bus.CYC_O, bus.STB_O, bus.SEL_O}); end
      bus.ACK_I = 1'b1;
      tick();
      bus.ACK_I = 1'b0;
      checks++;
      if (bus.CYC_O !== 1'b0) begin failures++; $display("FAIL sel_zero_end cyc=%b required 0", bus.CYC_O); end
   endtask

   task automatic test_both_and_hold();
      bus.read_i = 1'b1; bus.write_i = 1'b1; bus.adr_i = 32'h20; bus.cpu_dat_i = 32'hAAAA5555; bus.sel_i = 4'h3;
      tick();
      checks++;
      if ({bus.CYC_O, bus.WE_O} !== 2'b11) begin failures++; $display("FAIL both_write_wins cyc/we=%b required 11", {bus.CYC_O, bus.WE_O}); end
      bus.write_i = 1'b0; bus.adr_i = 32'h30; bus.cpu_dat_i = 32'h11111111; bus.sel_i = 4'hC;
      tick();
      checks++;
      if ({bus.ADR_O, bus.DAT_O, bus.SEL_O, bus.WE_O} !== {32'h20, 32'hAAAA5555, 4'h3, 1'b1}) begin
         failures++; $display("FAIL frozen adr=%h dat=%h sel=%h we=%b required 00000020 aaaa5555 3 1", bus.ADR_O, bus.DAT_O, bus.SEL_O, bus.WE_O);
      end
      bus.ACK_I = 1'b1;
      tick();
      bus.ACK_I = 1'b0;
      checks++;
      if (bus.CYC_O !== 1'b0) begin failures++; $display("FAIL idle_gap cyc=%b required 0", bus.CYC_O); end
      tick();
      bus.read_i = 1'b0;
      checks++;
      if ({bus.CYC_O, bus.WE_O, bus.ADR_O} !== {2'b10, 32'h30}) begin failures++; $display("FAIL held_restart cyc=%b we=%b adr=%h required 1 0 00000030", bus.CYC_O, bus.WE_O, bus.ADR_O); end
      bus.ACK_I = 1'b1; bus.DAT_I = 32'h0000BEEF;
      tick();
      bus.ACK_I = 1'b0;
      checks++;
      if ({bus.CYC_O, bus.cpu_dat_o} !== {1'b0, 32'h0000BEEF}) begin failures++; $display("FAIL held_read cyc=%b dat=%h required 0 0000beef", bus.CYC_O, bus.cpu_dat_o); end
   endtask

   task automatic test_timeout();
      bus.read_i = 1'b1; bus.adr_i = 32'h40;
      tick();
      bus.read_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({bus.CYC_O, bus.err_o} !== 2'b10) begin failures++; $display("FAIL timeout_wait%0d cyc/err=%b required 10", i, {bus.CYC_O, bus.err_o}); end
      end
      tick();
      checks++;
      if ({bus.CYC_O, bus.STB_O, bus.busy_o, bus.err_o} !== 4'b0001) begin failures++; $display("FAIL timeout_abort cyc/stb/busy/err=%b required 0001", {bus.CYC_O, bus.STB_O, bus.busy_o, bus.err_o}); end
      checks++;
      if (bus.cpu_dat_o !== 32'h0000BEEF) begin failures++; $display("FAIL timeout_data got=%h required=0000beef", bus.cpu_dat_o); end
      tick();
      checks++;
      if ({bus.err_o, bus.CYC_O} !== 2'b00) begin failures++; $display("FAIL timeout_err_pulse err/cyc=%b required 00", {bus.err_o, bus.CYC_O}); end
   endtask

   task automatic test_timeout_ack();
      bus.read_i = 1'b1; bus.adr_i = 32'h44;
      tick();
      bus.read_i = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (bus.CYC_O !== 1'b1) begin failures++; $display("FAIL late_ack_cycle4 cyc=%b required 1", bus.CYC_O); end
      bus.ACK_I = 1'b1; bus.DAT_I = 32'h00005A5A;
      tick();
      bus.ACK_I = 1'b0;
      checks++;
      if ({bus.CYC_O, bus.err_o, bus.cpu_dat_o} !== {2'b00, 32'h00005A5A}) begin failures++; $display("FAIL late_ack cyc=%b err=%b dat=%h required 0 0 00005a5a", bus.CYC_O, bus.err_o, bus.cpu_dat_o); end
      tick();
      checks++;
      if (bus.err_o !== 1'b0) begin failures++; $display("FAIL late_ack_no_err err=%b required 0", bus.err_o); end
   endtask

   task automatic test_reset_mid_bus();
      bus.read_i = 1'b1; bus.adr_i = 32'h60;
      tick();
      bus.read_i = 1'b0;
      checks++;
      if (bus.CYC_O !== 1'b1) begin failures++; $display("FAIL rst_pre cyc=%b required 1", bus.CYC_O); end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({bus.cpu_dat_o, bus.busy_o, bus.err_o, bus.ADR_O, bus.DAT_O, bus.SEL_O, bus.WE_O, bus.STB_O, bus.CYC_O} !== '0) begin
         failures++; $display("FAIL rst_async cyc=%b stb=%b busy=%b adr=%h dat=%h required all zero", bus.CYC_O, bus.STB_O, bus.busy_o, bus.ADR_O, bus.cpu_dat_o);
      end
      #2 rst = 1'b1;
      bus.ACK_I = 1'b1; bus.DAT_I = 32'h77777777;
      tick();
      bus.ACK_I = 1'b0;
      checks++;
      if ({bus.CYC_O, bus.busy_o, bus.err_o, bus.cpu_dat_o} !== '0) begin failures++; $display("FAIL rst_late_ack cyc=%b busy=%b err=%b dat=%h required 0 0 0 0", bus.CYC_O, bus.busy_o, bus.err_o, bus.cpu_dat_o); end
      tick();
      checks++;
      if (bus.CYC_O !== 1'b0) begin failures++; $display("FAIL rst_no_start cyc=%b required 0", bus.CYC_O); end
   endtask

   task automatic test_back_to_back();
      bus.read_i = 1'b1; bus.adr_i = 32'h50;
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++;
         if (bus.CYC_O !== 1'b1) begin failures++; $display("FAIL b2b_start%0d cyc=%b required 1", k, bus.CYC_O); end
         bus.ACK_I = 1'b1; bus.DAT_I = 32'(k);
         tick();
         bus.ACK_I = 1'b0;
         if (k == 3) bus.read_i = 1'b0;
         checks++;
         if ({bus.CYC_O, bus.cpu_dat_o} !== {1'b0, 32'(k)}) begin failures++; $display("FAIL b2b_data%0d cyc=%b dat=%h required 0 %h", k, bus.CYC_O, bus.cpu_dat_o, 32'(k)); end
      end
      tick();
      checks++;
      if (bus.CYC_O !== 1'b0) begin failures++; $display("FAIL b2b_stop cyc=%b required 0", bus.CYC_O); end
   endtask

   initial begin
      bus.read_i = 1'b0; bus.write_i = 1'b0; bus.adr_i = '0; bus.cpu_dat_i = '0;
      bus.sel_i = '0; bus.DAT_I = '0; bus.ACK_I = 1'b0;
      test_reset();
      test_read();
      test_write();
      test_sel_zero();
      test_both_and_hold();
      test_timeout();
      test_timeout_ack();
      test_reset_mid_bus();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wishbone_manager.md
Name: wishbone_manager

Overview:
- Sits directly downstream of the CPU request unit and converts its level-held read/write requests into single Wishbone classic bus cycles toward SRAM and peripherals.
- Returns read data and a busy indication to the request unit.
- Provides a bounded-wait timeout so a missing ACK cannot hang the pipeline.

Parameters:
ADR_WIDTH, 32, width of the address carried on adr_i and ADR_O
DAT_WIDTH, 32, data bus width; SEL width is DAT_WIDTH/8
TIMEOUT_CYCLES, 16, bus cycles without ACK before abort; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
read_i  in  1  read request from request unit, level-held
write_i  in  1  write request from request unit, level-held
adr_i  in  ADR_WIDTH  request address
cpu_dat_i  in  DAT_WIDTH  write data
sel_i  in  DAT_WIDTH/8  byte lane enables
cpu_dat_o  out  DAT_WIDTH  last read data returned to request unit
busy_o  out  1  transaction in progress
err_o  out  1  one-cycle pulse on timeout abort
ADR_O  out  ADR_WIDTH  Wishbone address
DAT_O  out  DAT_WIDTH  Wishbone write data
SEL_O  out  DAT_WIDTH/8  Wishbone byte select
WE_O  out  1  Wishbone write enable
STB_O  out  1  Wishbone strobe
CYC_O  out  1  Wishbone cycle
DAT_I  in  DAT_WIDTH  Wishbone read data
ACK_I  in  1  Wishbone acknowledge

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-low; when rst is low, all state is cleared immediately regardless of clk.
- Reset values:
  - state=IDLE; timeout counter=0.
  - All outputs 0: cpu_dat_o, busy_o, err_o, ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O.
- All outputs are registered; no combinational path from any input to any output.
- FSM has two states, IDLE and BUS.
- IDLE:
  - busy_o=0, CYC_O=STB_O=0.
  - At a clk edge with write_i|read_i high: latch adr_i->ADR_O, cpu_dat_i->DAT_O, sel_i->SEL_O, WE_O=write_i; set CYC_O=STB_O=busy_o=1; clear counter; go to BUS.
  - If read_i and write_i are both high, the write wins (WE_O=1).
  - ACK_I in IDLE is ignored.
- BUS:
  - ADR_O/DAT_O/SEL_O/WE_O stay frozen; changes on request inputs are ignored until return to IDLE.
  - ACK_I sampled high:
    - Next cycle CYC_O=STB_O=WE_O=busy_o=0; go to IDLE.
    - If WE_O=0, cpu_dat_o<=DAT_I.
    - Writes leave cpu_dat_o unchanged.
  - ACK_I low:
    - Counter increments, saturating.
    - If TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES-1 at the edge: abort. Deassert CYC_O/STB_O/busy_o, pulse err_o for exactly one cycle, leave cpu_dat_o unchanged, go to IDLE.
  - ACK_I arriving in the same cycle as the timeout condition: ACK wins, with normal completion and no err_o.
- Spacing and latency:
  - Mandatory at least one IDLE cycle between transactions; a request held continuously starts a new cycle on the edge after returning to IDLE.
  - Minimum read latency: request sampled at edge N, CYC_O high in cycle N+1, slave ACK in that cycle, cpu_dat_o valid and busy_o low after edge N+2.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1 bit.
- sel_i==0 still generates a full bus cycle; the slave decides the effect.
- Reset asserted mid-BUS drops CYC_O/STB_O immediately (asynchronous) with no err_o; a late ACK_I after reset release is ignored in IDLE.
- err_o is never high for two consecutive cycles.

Test Plan:
1. Read: read_i=1, adr_i=0x10, slave ACKs 1 cycle after STB_O with DAT_I=0xCAFEF00D -> ADR_O=0x10, WE_O=0, CYC_O/STB_O high exactly 2 cycles, cpu_dat_o=0xCAFEF00D, busy_o falls with CYC_O, err_o=0.
2. Write: write_i=1, adr_i=0x04, cpu_dat_i=0x12345678, sel_i=0xF, immediate ACK -> DAT_O=0x12345678, SEL_O=0xF, WE_O=1 during CYC_O; cpu_dat_o keeps the prior value.
3. Both read_i and write_i high, plus input changes mid-BUS -> WE_O=1; ADR_O/DAT_O hold the values latched at start; after ACK there is one IDLE cycle, then a new cycle starts if a request is still held.
4. Timeout: TIMEOUT_CYCLES=4, no ACK -> CYC_O drops after the 4th BUS cycle, err_o=1 for exactly one cycle, cpu_dat_o unchanged; the same run with ACK on the 4th cycle -> normal completion, err_o=0.
5. Reset mid-BUS: assert rst low between clk edges while CYC_O=1 -> all outputs 0 immediately; after release, an ACK_I pulse is ignored and no transaction starts without a request.
6. Back-to-back reads held for 3 transactions with DAT_I=1,2,3 -> cpu_dat_o sequence 1,2,3; exactly one IDLE cycle with CYC_O=0 between each pair.
